demux8_buf: RTL and testbench

DEMUX8_BUF -- requirements
Module: demux8_buf

---
 rtl/demux8_buf_if.sv | 30 +++
 rtl/demux8_buf.sv | 61 ++++++
 tb/tb_demux8_buf.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/demux8_buf_if.sv
// rtl/demux8_buf_if.sv - handshake and channel bundle for the 1-to-8 buffered demux
interface demux8_buf_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] d;
    logic [2:0]       s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [WIDTH-1:0] y4;
    logic [WIDTH-1:0] y5;
    logic [WIDTH-1:0] y6;
    logic [WIDTH-1:0] y7;
    logic [7:0]       vld;
    logic [7:0]       ack;
    logic             busy;

    modport master (
        output d, s, in_valid, ack,
        input  in_ready, y0, y1, y2, y3, y4, y5, y6, y7, vld, busy
    );

    modport slave (
        input  d, s, in_valid, ack,
        output in_ready, y0, y1, y2, y3, y4, y5, y6, y7, vld, busy
    );
endinterface

// File: rtl/demux8_buf.sv
// rtl/demux8_buf.sv - two-stage buffered 1-to-8 demultiplexer with per-channel consume strobes
module demux8_buf #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    demux8_buf_if.slave bus
);
    logic             s1_full;
    logic [2:0]       s1_sel;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] y_q [8];
    logic [7:0]       vld_q;
    logic             dispatch;
    logic             take;

    // A channel can take the staged word if it is empty or being consumed this edge.
    assign dispatch     = s1_full & (~vld_q[s1_sel] | bus.ack[s1_sel]);
    assign bus.in_ready = ~rst_n | ~s1_full | dispatch;
    assign take         = bus.in_valid & bus.in_ready;
    assign bus.busy     = rst_n & (s1_full | (|vld_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_sel  <= 3'd0;
            s1_data <= '0;
            vld_q   <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            if (take) begin
                s1_full <= 1'b1;
                s1_sel  <= bus.s;
                s1_data <= bus.d;
            end else if (dispatch) begin
                s1_full <= 1'b0;
            end
            // A load into channel k wins over its own consume on the same edge.
            for (int k = 0; k < 8; k++) begin
                if (dispatch && (s1_sel == 3'(k))) begin
                    y_q[k]   <= s1_data;
                    vld_q[k] <= 1'b1;
                end else if (bus.ack[k] && vld_q[k]) begin
                    vld_q[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.vld = vld_q;
    assign bus.y0  = y_q[0];
    assign bus.y1  = y_q[1];
    assign bus.y2  = y_q[2];
    assign bus.y3  = y_q[3];
    assign bus.y4  = y_q[4];
    assign bus.y5  = y_q[5];
    assign bus.y6  = y_q[6];
    assign bus.y7  = y_q[7];
endmodule

// File: tb/tb_demux8_buf.sv
// tb/tb_demux8_buf.sv - randomized and directed self-checking bench for demux8_buf
module tb_demux8_buf;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux8_buf_if #(.WIDTH(W)) bus ();
    demux8_buf #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    // reference: one staging slot, eight channel slots, per-channel acceptance-order queues
    logic         m_init = 1'b0;
    logic         m_full = 1'b0;
    logic [2:0]   m_sel  = 3'd0;
    logic [W-1:0] m_data = '0;
    logic [7:0]   m_vld  = 8'h00;
    logic [W-1:0] m_y [8];
    logic [W-1:0] sbq [8][$];
    logic         last_rdy;
    logic         last_busy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_y(input int k);
        case (k)
            0: return bus.y0;
            1: return bus.y1;
            2: return bus.y2;
            3: return bus.y3;
            4: return bus.y4;
            5: return bus.y5;
            6: return bus.y6;
            default: return bus.y7;
        endcase
    endfunction

    task automatic cyc(input logic r, input logic iv, input logic [W-1:0] dd,
                       input logic [2:0] ss, input logic [7:0] ak);
        logic disp;
        logic rdy;
        logic acc;
        rst_n        = r;
        bus.in_valid = iv;
        bus.d        = dd;
        bus.s        = ss;
        bus.ack      = ak;
        #2;
        disp = m_full && (!m_vld[m_sel] || ak[m_sel]);
        rdy  = !r || !m_full || disp;
        last_rdy  = bus.in_ready;
        last_busy = bus.busy;
        if (m_init) begin
            check_eq("in_ready", bus.in_ready, rdy);
            check_eq("busy", bus.busy, r && (m_full || (m_vld != 0)));
            check_eq("vld", bus.vld, m_vld);
            for (int k = 0; k < 8; k++) begin
                check_eq($sformatf("y%0d", k), dut_y(k), m_y[k]);
            end
            if (r) begin
                for (int k = 0; k < 8; k++) begin
                    if (bus.vld[k] && ak[k]) begin
                        check_eq($sformatf("order_ch%0d", k), dut_y(k),
                                 (sbq[k].size() > 0) ? sbq[k][0] : 'x);
                        if (sbq[k].size() > 0) void'(sbq[k].pop_front());
                    end
                end
            end
        end
        @(posedge clk);
        if (!r) begin
            m_init = 1'b1;
            m_full = 1'b0;
            m_sel  = 3'd0;
            m_data = '0;
            m_vld  = 8'h00;
            for (int k = 0; k < 8; k++) begin
                m_y[k] = '0;
                sbq[k].delete();
            end
        end else begin
            acc = iv && rdy;
            for (int k = 0; k < 8; k++) begin
                if (disp && m_sel == 3'(k)) begin
                    m_y[k]   = m_data;
                    m_vld[k] = 1'b1;
                end else if (ak[k]) begin
                    m_vld[k] = 1'b0;
                end
            end
            if (acc) begin
                m_full = 1'b1;
                m_sel  = ss;
                m_data = dd;
                sbq[ss].push_back(dd);
            end else if (disp) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] wa;
        for (int k = 0; k < 8; k++) m_y[k] = '0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.d = '0;
        bus.s = 3'd0;
        bus.ack = 8'h00;

        cyc(0, 0, '0, 0, 8'h00);
        cyc(0, 1, 32'hdeadbeef, 5, 8'hff);
        check_eq("rst_rdy", last_rdy, 1);
        check_eq("rst_busy", last_busy, 0);
        check_eq("rst_vld", bus.vld, 8'h00);
        check_eq("rst_y5", bus.y5, 0);

        // single word, first edge after reset
        cyc(1, 1, 32'hffff1111, 0, 8'h00);
        cyc(1, 0, '0, 0, 8'h00);
        check_eq("single_vld", bus.vld, 8'h01);
        check_eq("single_y0", bus.y0, 32'hffff1111);
        for (int k = 1; k < 8; k++) check_eq($sformatf("single_y%0d", k), dut_y(k), 0);

        // back-to-back to all channels
        cyc(0, 0, '0, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            wa = {16'hffff, {4{4'(k + 1)}}};
            cyc(1, 1, wa, 3'(k), 8'h00);
            check_eq($sformatf("b2b_rdy%0d", k), last_rdy, 1);
        end
        cyc(1, 0, '0, 0, 8'h00);
        check_eq("b2b_vld", bus.vld, 8'hff);
        for (int k = 0; k < 8; k++)
            check_eq($sformatf("b2b_y%0d", k), dut_y(k), {16'hffff, {4{4'(k + 1)}}});

        // stall on busy channel 2, release with one ack pulse
        cyc(1, 1, 32'haaaa0002, 2, 8'h00);
        cyc(1, 1, 32'hbbbb0002, 2, 8'h00);
        check_eq("stall_rdy", last_rdy, 0);
        cyc(1, 1, 32'hbbbb0002, 2, 8'h04);
        check_eq("release_rdy", last_rdy, 1);
        check_eq("release_y2", bus.y2, 32'haaaa0002);
        check_eq("release_vld", bus.vld, 8'hff);
        cyc(1, 0, '0, 0, 8'hff);
        check_eq("drain_y2", bus.y2, 32'hbbbb0002);
        check_eq("drain_vld", bus.vld, 8'h04);
        cyc(1, 0, '0, 0, 8'hff);
        check_eq("drained_vld", bus.vld, 8'h00);

        // same-edge ack and dispatch on channel 3
        cyc(1, 1, 32'hc3c30001, 3, 8'h00);
        cyc(1, 1, 32'hc3c30002, 3, 8'h00);
        cyc(1, 1, 32'hc3c30003, 3, 8'h08);
        check_eq("same_rdy", last_rdy, 1);
        check_eq("same_vld", bus.vld, 8'h08);
        check_eq("same_y3", bus.y3, 32'hc3c30002);
        cyc(1, 0, '0, 0, 8'h08);
        check_eq("same2_y3", bus.y3, 32'hc3c30003);
        check_eq("same2_vld", bus.vld, 8'h08);
        cyc(1, 0, '0, 0, 8'h08);

        // stray acks on empty channels
        cyc(1, 0, '0, 0, 8'hff);
        cyc(1, 0, '0, 0, 8'hff);
        check_eq("stray_vld", bus.vld, 8'h00);
        check_eq("stray_busy", last_busy, 0);
        check_eq("stray_y3", bus.y3, 32'hc3c30003);

        // reset with stage 1 full and vld=5a
        cyc(1, 1, 32'h11110001, 1, 8'h00);
        cyc(1, 1, 32'h11110003, 3, 8'h00);
        cyc(1, 1, 32'h11110004, 4, 8'h00);
        cyc(1, 1, 32'h11110006, 6, 8'h00);
        cyc(1, 1, 32'h2222000a, 1, 8'h00);
        check_eq("pre_rst_vld", bus.vld, 8'h5a);
        cyc(0, 0, '0, 0, 8'h00);
        check_eq("mid_rst_vld", bus.vld, 8'h00);
        for (int k = 0; k < 8; k++) check_eq($sformatf("mid_rst_y%0d", k), dut_y(k), 0);
        cyc(1, 0, '0, 0, 8'h00);
        check_eq("mid_rst_rdy", last_rdy, 1);
        check_eq("mid_rst_busy", last_busy, 0);

        // random traffic against the reference
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) != 0), W'($urandom),
                3'($urandom_range(0, 7)), 8'($urandom & $urandom));
        end
        for (int i = 0; i < 20; i++) cyc(1, 0, '0, 0, 8'hff);
        check_eq("final_vld", bus.vld, 8'h00);
        check_eq("final_busy", last_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
